// File: rtl/floating_point_coef_pkg.sv
// Shared types and coefficient tables for the reciprocal-datapath coefficient sequencer.
// Single-precision words occupy the low 32 bits of the 64-bit table entries.
package floating_point_coef_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SPECIAL_TABLE = 2'b00,
        SPECIAL_INF   = 2'b01,
        SPECIAL_QNAN  = 2'b10,
        SPECIAL_ZERO  = 2'b11
    } special_e;

    localparam int TAB_EXPLICIT = 8;

    localparam logic [31:0] SINGLE_TAB [TAB_EXPLICIT] = '{
        32'he2f784c5, 32'hd513d2aa, 32'h72aff7e5, 32'hbbd27277,
        32'h8932d612, 32'h47ecdb8f, 32'h793069f2, 32'h00000000
    };
    localparam logic [31:0] SINGLE_TAIL = 32'he77696ce;

    localparam logic [63:0] DOUBLE_TAB [TAB_EXPLICIT] = '{
        64'hbbd27277e2f784c5, 64'hd513d2aa793069f2, 64'h72aff7e5e2f784c5, 64'hd513d2aabbd27277,
        64'h72aff7e58932d612, 64'h47ecdb8fe77696ce, 64'h793069f28932d612, 64'h0000000000000000
    };
    localparam logic [63:0] DOUBLE_TAIL = 64'he77696ce47ecdb8f;

    // Every index at or beyond TAB_EXPLICIT returns the tail constant.
    function automatic logic [63:0] coef_word(input logic dbl, input logic [31:0] idx);
        logic [63:0] w;
        if (idx < 32'(TAB_EXPLICIT)) begin
            w = dbl ? DOUBLE_TAB[idx[2:0]] : {32'h0, SINGLE_TAB[idx[2:0]]};
        end else begin
            w = dbl ? DOUBLE_TAIL : {32'h0, SINGLE_TAIL};
        end
        return w;
    endfunction

endpackage

// File: rtl/floating_point_coef_rom.sv
// Registered-output coefficient table: data follows addr by exactly one clock.
// Deliberately has no reset so it maps onto block ROM.
module floating_point_coef_rom
    import floating_point_coef_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MAN_WIDTH  = 23,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic [ADDR_WIDTH-1:0]          addr,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   data
);

    localparam int   W   = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam logic DBL = (EXP_WIDTH != 8);

    always_ff @(posedge clk) begin
        data <= W'(coef_word(DBL, 32'(addr)));
    end

endmodule

// File: rtl/floating_point_coef_seq.sv
// Burst coefficient sequencer: one request in, a stream of table (or special) words out.
// Handshakes: a transfer happens on any posedge where valid && ready are both high.
module floating_point_coef_seq
    import floating_point_coef_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MAN_WIDTH  = 23,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WIDTH-1:0]        req_base,
    input  logic [ADDR_WIDTH-1:0]        req_len_m1,
    input  logic [1:0]                   req_special,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0] out_data,
    output logic                         out_last,
    output logic [ADDR_WIDTH-1:0]        out_idx,
    output logic                         busy
);

    localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;

    function automatic logic [W-1:0] special_word(input special_e mode);
        logic [W-1:0] w;
        case (mode)
            SPECIAL_INF:  w = {1'b0, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            SPECIAL_QNAN: w = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
            default:      w = '0;
        endcase
        return w;
    endfunction

    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_cnt, len_m1_q;
    special_e              special_q;

    logic                  inflight, inflight_last, inflight_special;
    logic [ADDR_WIDTH-1:0] inflight_idx;
    logic [W-1:0]          inj_word_q, rom_data, capture_word;

    logic [W-1:0]          fifo_data [2];
    logic [ADDR_WIDTH-1:0] fifo_idx  [2];
    logic                  fifo_last [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_count;

    logic                  issue, last_read, push, pop;
    logic [2:0]            occupancy;

    floating_point_coef_rom #(
        .EXP_WIDTH (EXP_WIDTH),
        .MAN_WIDTH (MAN_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rom (
        .clk (clk),
        .addr(rd_addr),
        .data(rom_data)
    );

    assign push         = inflight;
    assign pop          = out_valid && out_ready;
    assign capture_word = inflight_special ? inj_word_q : rom_data;

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_idx   = fifo_idx[rd_ptr];
    assign out_last  = out_valid && fifo_last[rd_ptr];
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        occupancy = {1'b0, fifo_count} + {2'b00, inflight};
        last_read = (special_q != SPECIAL_TABLE) || (rd_cnt == len_m1_q);
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = FETCH;
            end
            FETCH: begin
                // A pop this cycle frees a slot in time for the read issued now,
                // which keeps the stream at one beat per cycle without overflow.
                issue = (occupancy < 3'd2) || pop;
                if (issue && last_read) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            rd_addr          <= '0;
            rd_cnt           <= '0;
            len_m1_q         <= '0;
            special_q        <= SPECIAL_TABLE;
            inflight         <= 1'b0;
            inflight_last    <= 1'b0;
            inflight_special <= 1'b0;
            inflight_idx     <= '0;
            inj_word_q       <= '0;
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            fifo_count       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            state    <= state_nxt;
            inflight <= issue;

            if (state == IDLE && req_valid) begin
                rd_addr   <= req_base;
                rd_cnt    <= '0;
                len_m1_q  <= req_len_m1;
                special_q <= special_e'(req_special);
            end

            // rd_addr wraps naturally modulo the table depth.
            if (issue) begin
                rd_addr          <= rd_addr + 1'b1;
                rd_cnt           <= rd_cnt + 1'b1;
                inflight_last    <= last_read;
                inflight_special <= (special_q != SPECIAL_TABLE);
                inflight_idx     <= (special_q != SPECIAL_TABLE) ? '0 : rd_addr;
                inj_word_q       <= special_word(special_q);
            end

            if (push) begin
                fifo_data[wr_ptr] <= capture_word;
                fifo_idx[wr_ptr]  <= inflight_idx;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end

            if (pop) rd_ptr <= ~rd_ptr;

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_coef_seq.sv
// Directed bench for floating_point_coef_seq: single-precision instance plus a
// double-precision instance for the special-mode words.
module tb_floating_point_coef_seq;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, out_valid, out_ready, out_last, busy;
    logic [3:0]  req_base, req_len_m1, out_idx;
    logic [1:0]  req_special;
    logic [31:0] out_data;

    logic        d_req_valid, d_req_ready, d_out_valid, d_out_ready, d_out_last, d_busy;
    logic [3:0]  d_req_base, d_req_len_m1, d_out_idx;
    logic [1:0]  d_req_special;
    logic [63:0] d_out_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    floating_point_coef_seq u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
        .req_len_m1(req_len_m1), .req_special(req_special),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_idx(out_idx), .busy(busy)
    );

    floating_point_coef_seq #(.EXP_WIDTH(11), .MAN_WIDTH(52), .ADDR_WIDTH(4)) u_dbl (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_base(d_req_base),
        .req_len_m1(d_req_len_m1), .req_special(d_req_special),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
        .out_last(d_out_last), .out_idx(d_out_idx), .busy(d_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] single_coef(input int idx);
        case (idx)
            0: return 32'he2f784c5;
            1: return 32'hd513d2aa;
            2: return 32'h72aff7e5;
            3: return 32'hbbd27277;
            4: return 32'h8932d612;
            5: return 32'h47ecdb8f;
            6: return 32'h793069f2;
            7: return 32'h00000000;
            default: return 32'he77696ce;
        endcase
    endfunction

    // Request is accepted on the posedge inside this task (edge T); returns at T+1ns.
    task automatic send_req(input logic [3:0] base, input logic [3:0] len_m1, input logic [1:0] sp);
        req_base    = base;
        req_len_m1  = len_m1;
        req_special = sp;
        req_valid   = 1'b1;
        @(posedge clk); #1;
        req_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %0b exp 0", out_last); end
        checks++; if (out_idx !== 4'h0) begin errors++; $display("FAIL reset_out_idx got %0d exp 0", out_idx); end
        checks++; if (d_out_data !== 64'h0) begin errors++; $display("FAIL reset_d_out_data got %h exp 0", d_out_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [31:0] e;
        exp_q = '{32'h72aff7e5, 32'hbbd27277, 32'h8932d612};
        send_req(4'd2, 4'd2, 2'b00);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b exp 1", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL single_req_ready_busy got %0b exp 0", req_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency_t1 got %0b exp 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d got %0b exp 1", i, out_valid); end
            checks++; if (out_data !== e) begin errors++; $display("FAIL single_data beat %0d got %h exp %h", i, out_data, e); end
            checks++; if (out_idx !== 4'(2 + i)) begin errors++; $display("FAIL single_idx beat %0d got %0d exp %0d", i, out_idx, 2 + i); end
            checks++; if (out_last !== (i == 2)) begin errors++; $display("FAIL single_last beat %0d got %0b exp %0b", i, out_last, i == 2); end
        end
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_req_ready_t5 got %0b exp 1", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t5 got %0b exp 0", out_valid); end
    endtask

    task automatic test_wrap();
        send_req(4'd15, 4'd1, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        checks++; if (out_idx !== 4'd15) begin errors++; $display("FAIL wrap_idx0 got %0d exp 15", out_idx); end
        checks++; if (out_data !== 32'he77696ce) begin errors++; $display("FAIL wrap_data0 got %h exp e77696ce", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL wrap_last0 got %0b exp 0", out_last); end
        @(posedge clk); #1;
        checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL wrap_idx1 got %0d exp 0", out_idx); end
        checks++; if (out_data !== 32'he2f784c5) begin errors++; $display("FAIL wrap_data1 got %h exp e2f784c5", out_data); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL wrap_last1 got %0b exp 1", out_last); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic        pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] e, prev_data;
        logic        prev_stall;
        int          got, k;
        got = 0; k = 0; prev_stall = 1'b0; prev_data = '0;
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back(single_coef(i));
        send_req(4'd0, 4'd6, 2'b00);
        for (int cyc = 0; cyc < 60 && got < 7; cyc++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (prev_stall) begin
                    checks++; if (out_data !== prev_data) begin errors++; $display("FAIL bp_stable got %h exp %h", out_data, prev_data); end
                end
                out_ready = pat[k % 6];
                k++;
                if (out_ready) begin
                    e = exp_q.pop_front();
                    checks++; if (out_data !== e) begin errors++; $display("FAIL bp_data beat %0d got %h exp %h", got, out_data, e); end
                    checks++; if (out_idx !== 4'(got)) begin errors++; $display("FAIL bp_idx beat %0d got %0d exp %0d", got, out_idx, got); end
                    checks++; if (out_last !== (got == 6)) begin errors++; $display("FAIL bp_last beat %0d got %0b exp %0b", got, out_last, got == 6); end
                    got++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = out_data;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
        checks++; if (got != 7) begin errors++; $display("FAIL bp_beat_count got %0d exp 7", got); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_req_ready_after got %0b exp 1", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra_beat got %0b exp 0", out_valid); end
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < 16; i++) exp_q.push_back(single_coef((9 + i) % 16));
        send_req(4'd9, 4'd15, 2'b00);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] e;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || out_data !== e) begin errors++; $display("FAIL full_data beat %0d got %0b/%h exp 1/%h", i, out_valid, out_data, e); end
            checks++; if (out_idx !== 4'((9 + i) % 16)) begin errors++; $display("FAIL full_idx beat %0d got %0d exp %0d", i, out_idx, (9 + i) % 16); end
            checks++; if (out_last !== (i == 15)) begin errors++; $display("FAIL full_last beat %0d got %0b exp %0b", i, out_last, i == 15); end
        end
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_req_ready got %0b exp 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        send_req(4'd7, 4'd0, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        checks++; if (out_data !== 32'h0 || out_idx !== 4'd7 || out_last !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%0d/%0b exp 0/7/1", out_data, out_idx, out_last); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b exp 1", req_ready); end
        send_req(4'd8, 4'd0, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'he77696ce || out_idx !== 4'd8) begin errors++; $display("FAIL b2b_second got %0b/%h/%0d exp 1/e77696ce/8", out_valid, out_data, out_idx); end
        @(posedge clk); #1;
    endtask

    task automatic test_special();
        logic [1:0]  modes [2] = '{2'b01, 2'b11};
        logic [31:0] words [2] = '{32'h7f800000, 32'h00000000};
        d_req_base = 4'd5; d_req_len_m1 = 4'd3; d_req_special = 2'b10; d_req_valid = 1'b1;
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL dbl_latency_t1 got %0b exp 0", d_out_valid); end
        @(posedge clk); #1;
        checks++; if (d_out_valid !== 1'b1 || d_out_data !== 64'h7ff8000000000000) begin errors++; $display("FAIL dbl_qnan got %0b/%h exp 1/7ff8000000000000", d_out_valid, d_out_data); end
        checks++; if (d_out_last !== 1'b1 || d_out_idx !== 4'd0) begin errors++; $display("FAIL dbl_qnan_last_idx got %0b/%0d exp 1/0", d_out_last, d_out_idx); end
        @(posedge clk); #1;
        checks++; if (d_out_valid !== 1'b0 || d_req_ready !== 1'b1) begin errors++; $display("FAIL dbl_single_beat got valid %0b ready %0b exp 0/1", d_out_valid, d_req_ready); end
        for (int m = 0; m < 2; m++) begin
            send_req(4'd3, 4'd2, modes[m]);
            @(posedge clk); @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_data !== words[m]) begin errors++; $display("FAIL sp_word mode %0d got %0b/%h exp 1/%h", modes[m], out_valid, out_data, words[m]); end
            checks++; if (out_last !== 1'b1 || out_idx !== 4'd0) begin errors++; $display("FAIL sp_last_idx mode %0d got %0b/%0d exp 1/0", modes[m], out_last, out_idx); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sp_one_beat mode %0d got %0b/%0b exp 0/1", modes[m], out_valid, req_ready); end
        end
    endtask

    task automatic test_reset_mid();
        send_req(4'd0, 4'd4, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        checks++; if (out_data !== 32'he2f784c5) begin errors++; $display("FAIL mid_beat0 got %h exp e2f784c5", out_data); end
        @(posedge clk); #1;
        checks++; if (out_data !== 32'hd513d2aa) begin errors++; $display("FAIL mid_beat1 got %h exp d513d2aa", out_data); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_after_reset got %0b exp 0", out_valid); end
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_idle_after_reset got busy %0b ready %0b exp 0/1", busy, req_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_released got %0b/%0b exp 0/1", out_valid, req_ready); end
        send_req(4'd0, 4'd0, 2'b00);
        @(posedge clk); @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'he2f784c5 || out_idx !== 4'd0 || out_last !== 1'b1) begin errors++; $display("FAIL mid_new_req got %0b/%h/%0d/%0b exp 1/e2f784c5/0/1", out_valid, out_data, out_idx, out_last); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_base = '0; req_len_m1 = '0; req_special = '0; out_ready = 1'b1;
        d_req_valid = 1'b0; d_req_base = '0; d_req_len_m1 = '0; d_req_special = '0; d_out_ready = 1'b1;
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_full_depth();
        test_back_to_back();
        test_special();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
